axi_write_route_scheduler: RTL
==============================

Name: axi_write_route_scheduler

Overview:
- Sequences the AXI write-data (W) channel of the interconnect.
- Queues every accepted write-address (AW) handshake as a route entry: source master, target slave, burst length.
- Presents the head entry as the W-channel mux select, counts data beats against the recorded length, and retires the entry on the final beat.
- Sits between the AW arbiter and the W-channel data mux. W bursts are forwarded strictly in AW acceptance order. Enforces AWLEN/WLAST consistency.

Parameters:
- DEPTH, 4, route FIFO entries; power of two, minimum 2.
- NSLV, 6, number of slave ports; slave index 0 is ROM (read-only).
- LEN_W, 4, burst length field width (AWLEN, beats = len+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- aw_valid  in  1  AW handshake request from the AW arbiter
- aw_ready  out  1  route FIFO can accept an entry
- aw_master  in  1  source master (0 = M1, 1 = M2)
- aw_slave  in  3  decoded target slave index
- aw_len  in  LEN_W  AWLEN of the burst
- route_valid  out  1  a head route is active
- route_master  out  1  head entry master select for the W mux
- route_slave  out  3  head entry slave select for the W mux
- route_sink  out  1  head targets slave 0 or an index >= NSLV; the W mux must drive WREADY=1 locally and drop the data
- w_hs  in  1  WVALID&WREADY observed on the routed path this cycle
- w_last  in  1  WLAST of the routed master
- beat_cnt  out  LEN_W  beats completed in the current burst
- burst_done  out  1  one-cycle pulse when the head entry retires
- err  out  1  sticky WLAST mismatch flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (rst low, asynchronous): FIFO empty; wr/rd pointers=0; beat_cnt=0; err=0; burst_done=0. Outputs then read aw_ready=1, route_valid=0, route_master=0, route_slave=0, route_sink=0.
- aw_ready = !full. It is combinational from the registered occupancy count only and never depends on a same-cycle pop.
- Push:
  - Occurs when aw_valid & aw_ready.
  - Stores {aw_master, aw_slave, aw_len} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - aw_valid while full: no push, no state change. The arbiter holds the request.
- Head outputs:
  - route_valid = !empty.
  - route_master, route_slave, route_len are read from the entry at rd_ptr; these outputs are 0 when empty.
  - route_sink = route_valid & (route_slave==0 | route_slave>=NSLV).
  - An entry pushed into an empty FIFO becomes visible the cycle after the push (1-cycle latency).
- Beat counting:
  - w_hs while route_valid: if beat_cnt==route_len the burst is final, else beat_cnt increments.
  - w_hs while !route_valid is ignored.
- Retire, on the final beat:
  - beat_cnt returns to 0; rd_ptr advances modulo DEPTH; burst_done pulses high the next cycle for 1 cycle.
- Simultaneous push and retire:
  - Both take effect; occupancy is unchanged.
  - When not full this includes push to the wrapped slot.
- WLAST check, on each w_hs with route_valid:
  - Final beat with w_last=0 sets err.
  - Non-final beat with w_last=1 sets err.
  - The burst still retires on beat_cnt only.
- err:
  - Sticky; cleared by err_clr when no new mismatch occurs that cycle.
  - Simultaneous set and clear: set wins.
- Occupancy counter width is log2(DEPTH)+1; full = count==DEPTH; empty = count==0.
- Reset mid-burst: all queued routes are discarded and the counter is cleared. No partial state survives.

Test Plan:
- Reset then single-beat write: push {M1, slave 2, len 0}; next cycle route_valid=1, route_master=0, route_slave=2. w_hs+w_last -> burst_done pulse; route_valid=0; err=0.
- 4-beat burst: push {M2, slave 5, len 3}; beat_cnt steps 0->1->2->3. Retire on 4th w_hs with w_last=1; idle cycles with w_hs=0 hold the count.
- Ordering/full: push 4 entries (slaves 1, 2, 3, 4) back-to-back -> aw_ready=0 after the 4th; a 5th aw_valid is held. Each retire frees one slot. Routes present in order 1, 2, 3, 4; pointers wrap correctly on the next push.
- Simultaneous push/retire when full-1 (3 entries): count stays 3; aw_ready stays 1.
- WLAST errors:
  - len 1 burst with w_last=1 on beat 0 -> err=1; burst still needs 2 beats.
  - Then err_clr -> err=0.
  - len 0 with w_last=0 -> err=1.
- Sink and reset: push slave 0 -> route_sink=1. Push slave 7 -> route_sink=1. Assert rst mid-burst of a len 3 entry -> everything returns to reset values immediately.

Source files
------------

// File: rtl/axi_write_route_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_route_scheduler
// Brief    : Queues accepted AW handshakes as {master, slave, len} route
//            entries and steers the W channel through the head entry. It
//            counts beats, retires the entry on the final beat and flags
//            WLAST disagreements with AWLEN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_write_route_scheduler #(
  parameter int DEPTH = 4,
  parameter int NSLV  = 6,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aw_valid,
  output logic             aw_ready,
  input  logic             aw_master,
  input  logic [2:0]       aw_slave,
  input  logic [LEN_W-1:0] aw_len,
  output logic             route_valid,
  output logic             route_master,
  output logic [2:0]       route_slave,
  output logic             route_sink,
  input  logic             w_hs,
  input  logic             w_last,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             burst_done,
  output logic             err,
  input  logic             err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = LEN_W + 4;

  // Entry layout: {master, slave[2:0], len[LEN_W-1:0]}
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             burst_done_q, burst_done_d;
  logic             err_q, err_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             beat;
  logic             final_beat;
  logic             mismatch;
  logic [ENT_W-1:0] head;
  logic [LEN_W-1:0] route_len;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // aw_ready looks only at registered occupancy, so a same-cycle retire
  // never opens a slot early.
  assign aw_ready = !full;
  assign push     = aw_valid && !full;

  assign head         = mem_q[rd_ptr_q];
  assign route_valid  = !empty;
  assign route_master = route_valid ? head[ENT_W-1] : 1'b0;
  assign route_slave  = route_valid ? head[LEN_W+2:LEN_W] : 3'd0;
  assign route_len    = route_valid ? head[LEN_W-1:0] : '0;
  // Slave 0 is read-only ROM and indices past NSLV decode to nothing; both
  // are absorbed locally by the W mux.
  assign route_sink   = route_valid &&
                        ((route_slave == 3'd0) || ({29'd0, route_slave} >= 32'(NSLV)));

  // Beats while the queue is empty have no route and are ignored.
  assign beat       = w_hs && route_valid;
  assign final_beat = beat && (beat_cnt_q == route_len);
  assign pop        = final_beat;
  assign mismatch   = beat && (final_beat != w_last);

  assign beat_cnt   = beat_cnt_q;
  assign burst_done = burst_done_q;
  assign err        = err_q;

  // Per-slot write-enable: only the slot under wr_ptr takes the new entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_comb begin
      mem_d[i] = mem_q[i];
      if (push && (wr_ptr_q == PTR_W'(i))) begin
        mem_d[i] = {aw_master, aw_slave, aw_len};
      end
    end
  end

  // Pointer, occupancy, beat counter and status next-state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_cnt_d   = beat_cnt_q;
    burst_done_d = pop;
    err_d        = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (final_beat) begin
      beat_cnt_d = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + LEN_W'(1);
    end

    // A fresh mismatch beats a simultaneous clear.
    if (mismatch) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers; reset discards every queued route.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_done_q <= burst_done_d;
      err_q        <= err_d;
    end
  end

endmodule
`default_nettype wire
